// File: rtl/acc_pkg.sv
// Shared defaults and occupancy encoding for the conv accelerator output path.
package acc_pkg;

   localparam int DW_DEF    = 32;
   localparam int LANES_DEF = 56;
   localparam int ROWS_DEF  = 56;

   // Number of row banks holding a complete, not yet fully drained row.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_t;

   function automatic occ_t occ_of(input logic [1:0] full);
      occ_t o;
      case (full)
         2'b00:   o = OCC_EMPTY;
         2'b11:   o = OCC_TWO;
         default: o = OCC_ONE;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/fmap_par2ser_if.sv
// Row-in / word-out handshake bundle of the output serializer.
interface fmap_par2ser_if
   import acc_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int LANES = LANES_DEF
);
   logic [LANES*DW-1:0] par_i;
   logic                par_valid_i;
   logic                par_ready_o;
   logic [DW-1:0]       res_o;
   logic                res_valid_o;
   logic                res_ready_i;
   logic                res_last_o;
   logic                res_eoc_o;

   // master: the environment (row producer and result consumer)
   modport master (
      output par_i, par_valid_i, res_ready_i,
      input  par_ready_o, res_o, res_valid_o, res_last_o, res_eoc_o
   );

   // slave: the serializer itself
   modport slave (
      input  par_i, par_valid_i, res_ready_i,
      output par_ready_o, res_o, res_valid_o, res_last_o, res_eoc_o
   );
endinterface

// File: rtl/p2s_row_bank.sv
// One row buffer: whole-row parallel load, single word read by index.
module p2s_row_bank
   import acc_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int LANES = LANES_DEF,
   parameter int IDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ld,
   input  logic [LANES*DW-1:0] par_i,
   input  logic [IDX_W-1:0]    idx,
   output logic [DW-1:0]       word_o
);

   logic [DW-1:0] mem [LANES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LANES; k++) mem[k] <= '0;
      end else if (ld) begin
         for (int k = 0; k < LANES; k++) mem[k] <= par_i[k*DW +: DW];
      end
   end

   assign word_o = mem[idx];

endmodule

// File: rtl/fmap_par2ser.sv
// Output serializer: double-buffered PE-array rows streamed one word per cycle.
module fmap_par2ser
   import acc_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int LANES = LANES_DEF,
   parameter int ROWS  = ROWS_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   fmap_par2ser_if.slave bus
);

   localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LANES - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

   logic [1:0]       full;
   logic             wr_bank;
   logic             rd_bank;
   logic [IDX_W-1:0] idx;
   logic [ROW_W-1:0] row;

   logic             ld;
   logic             xfer;
   logic             row_done;
   logic [1:0]       ld_vec;
   logic [DW-1:0]    word [2];

   // Load and drain conditions depend only on registered flags plus the
   // partner's valid/ready, so par_ready_o never sees res_ready_i.
   assign ld       = bus.par_valid_i && !full[wr_bank];
   assign xfer     = full[rd_bank] && bus.res_ready_i;
   assign row_done = xfer && (idx == IDX_LAST);
   assign ld_vec   = {ld && wr_bank, ld && !wr_bank};

   for (genvar b = 0; b < 2; b++) begin : g_bank
      p2s_row_bank #(
         .DW    (DW),
         .LANES (LANES),
         .IDX_W (IDX_W)
      ) u_bank (
         .clk    (clk),
         .rst_n  (rst_n),
         .ld     (ld_vec[b]),
         .par_i  (bus.par_i),
         .idx    (idx),
         .word_o (word[b])
      );
   end

   // A load targets an empty bank and a drain an occupied one, so the two
   // full-flag updates below never touch the same bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full    <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         idx     <= '0;
         row     <= '0;
      end else begin
         if (ld) begin
            full[wr_bank] <= 1'b1;
            wr_bank       <= !wr_bank;
         end
         if (xfer) begin
            if (row_done) begin
               idx           <= '0;
               full[rd_bank] <= 1'b0;
               rd_bank       <= !rd_bank;
               row           <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

   assign bus.par_ready_o = !full[wr_bank];
   assign bus.res_valid_o = full[rd_bank];
   assign bus.res_o       = rd_bank ? word[1] : word[0];
   assign bus.res_last_o  = full[rd_bank] && (idx == IDX_LAST);
   assign bus.res_eoc_o   = full[rd_bank] && (idx == IDX_LAST) && (row == ROW_LAST);

endmodule

// File: tb/tb_fmap_par2ser.sv
// Randomised and directed bench for fmap_par2ser against a row-FIFO reference model.
module tb_fmap_par2ser;
   import acc_pkg::*;

   localparam int DW    = DW_DEF;
   localparam int LANES = LANES_DEF;
   localparam int ROWS  = ROWS_DEF;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   fmap_par2ser_if #(.DW(DW), .LANES(LANES)) bus ();

   fmap_par2ser #(.DW(DW), .LANES(LANES), .ROWS(ROWS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct { logic [DW-1:0] d; int k; } word_t;
   typedef struct { int cyc; logic [DW-1:0] d; logic last; logic eoc; } xfer_t;

   // Reference: buffered rows are a FIFO of words; occupancy counts whole rows.
   word_t q[$];
   xfer_t log_q[$];
   int    acc_cyc[$];
   occ_t  occ  = OCC_EMPTY;
   int    rowc = 0;
   int    cyc  = 0;
   int    checks = 0;
   int    errors = 0;

   bit    m_acc, m_xf, m_fin;
   word_t m_w;
   word_t m_nw;
   xfer_t m_e;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         occ  = OCC_EMPTY;
         rowc = 0;
      end else begin
         cyc++;
         m_acc = (bus.par_valid_i === 1'b1) && (occ != OCC_TWO);
         m_xf  = (occ != OCC_EMPTY) && (bus.res_ready_i === 1'b1);
         m_fin = 1'b0;
         if (m_xf && q.size() > 0) begin
            m_w    = q.pop_front();
            m_fin  = (m_w.k == LANES - 1);
            m_e.cyc  = cyc;
            m_e.d    = m_w.d;
            m_e.last = m_fin;
            m_e.eoc  = m_fin && (rowc == ROWS - 1);
            log_q.push_back(m_e);
            if (m_fin) rowc = (rowc + 1) % ROWS;
         end
         if (m_acc) begin
            for (int k = 0; k < LANES; k++) begin
               m_nw.d = bus.par_i[k*DW +: DW];
               m_nw.k = k;
               q.push_back(m_nw);
            end
            acc_cyc.push_back(cyc);
         end
         occ = occ_t'(int'(occ) + int'(m_acc) - int'(m_fin));
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_par_ready", 64'(bus.par_ready_o), 64'd1);
         chk("rst_res_valid", 64'(bus.res_valid_o), 64'd0);
         chk("rst_res_last",  64'(bus.res_last_o),  64'd0);
         chk("rst_res_eoc",   64'(bus.res_eoc_o),   64'd0);
      end else begin
         chk("par_ready", 64'(bus.par_ready_o), 64'(occ != OCC_TWO));
         chk("res_valid", 64'(bus.res_valid_o), 64'(occ != OCC_EMPTY));
         if (occ != OCC_EMPTY && q.size() > 0) begin
            chk("res_o",    64'(bus.res_o),      64'(q[0].d));
            chk("res_last", 64'(bus.res_last_o), 64'(q[0].k == LANES - 1));
            chk("res_eoc",  64'(bus.res_eoc_o),
                64'((q[0].k == LANES - 1) && (rowc == ROWS - 1)));
         end else begin
            chk("res_last_idle", 64'(bus.res_last_o), 64'd0);
            chk("res_eoc_idle",  64'(bus.res_eoc_o),  64'd0);
         end
      end
   end

   task automatic release_rst();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      log_q.delete();
      acc_cyc.delete();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      bus.par_valid_i = 1'b0;
      bus.res_ready_i = 1'b0;
      #1;
      chk("rst_immediate_res_o", 64'(bus.res_o), 64'd0);
      release_rst();
   endtask

   task automatic send_row(input logic [DW-1:0] base, input int budget);
      int n0;
      int b;
      n0 = acc_cyc.size();
      b  = budget;
      for (int k = 0; k < LANES; k++) bus.par_i[k*DW +: DW] = base + DW'(k);
      bus.par_valid_i = 1'b1;
      while (acc_cyc.size() == n0 && b > 0) begin
         @(posedge clk);
         #2;
         b--;
      end
      bus.par_valid_i = 1'b0;
      checks++;
      if (acc_cyc.size() == n0) begin
         errors++;
         $display("FAIL send_row_timeout base %0h: accepted 0, required 1", base);
      end
   endtask

   task automatic wait_log(input int n, input int budget);
      int b;
      b = budget;
      while (log_q.size() < n && b > 0) begin
         @(posedge clk);
         #2;
         b--;
      end
      checks++;
      if (log_q.size() < n) begin
         errors++;
         $display("FAIL wait_log_timeout: words %0d, required %0d", log_q.size(), n);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   int n_last;
   int n_eoc;
   int eoc_at;

   initial begin
      bus.par_i       = '0;
      bus.par_valid_i = 1'b0;
      bus.res_ready_i = 1'b0;
      do_reset();

      // Single row, words 1..56
      bus.res_ready_i = 1'b1;
      send_row(32'd1, 20);
      wait_log(LANES, 200);
      if (log_q.size() >= LANES) begin
         chk("t1_first_word", 64'(log_q[0].d), 64'd1);
         chk("t1_latency", 64'(log_q[0].cyc - acc_cyc[0]), 64'd1);
         chk("t1_last_word", 64'(log_q[55].d), 64'd56);
         chk("t1_last_flag", 64'(log_q[55].last), 64'd1);
         chk("t1_span", 64'(log_q[55].cyc - log_q[0].cyc), 64'd55);
         n_last = 0;
         foreach (log_q[i]) n_last += int'(log_q[i].last);
         chk("t1_last_count", 64'(n_last), 64'd1);
      end
      repeat (3) @(posedge clk);

      // Ping-pong with initial stall
      do_reset();
      fork
         begin
            send_row(32'h100, 50);
            send_row(32'h200, 50);
            send_row(32'h300, 300);
         end
         begin
            repeat (10) @(posedge clk);
            #2 bus.res_ready_i = 1'b1;
         end
      join
      wait_log(3 * LANES, 400);
      if (log_q.size() >= 3 * LANES && acc_cyc.size() == 3) begin
         chk("t2_row2_back_to_back", 64'(acc_cyc[1] - acc_cyc[0]), 64'd1);
         chk("t2_row3_accept", 64'(acc_cyc[2] - log_q[55].cyc), 64'd1);
         chk("t2_row2_first", 64'(log_q[56].d), 64'h200);
         chk("t2_row3_first", 64'(log_q[112].d), 64'h300);
         chk("t2_row3_last", 64'(log_q[167].d), 64'h337);
         chk("t2_no_gap", 64'(log_q[167].cyc - log_q[0].cyc), 64'd167);
      end

      // Random backpressure over one row
      do_reset();
      send_row(32'd1, 20);
      for (int b = 0; b < 1000 && log_q.size() < LANES; b++) begin
         bus.res_ready_i = 1'($urandom_range(0, 1));
         @(posedge clk);
         #2;
      end
      bus.res_ready_i = 1'b0;
      chk("t3_word_count", 64'(log_q.size()), 64'(LANES));
      if (log_q.size() >= LANES) begin
         for (int k = 0; k < LANES; k++) begin
            chk("t3_order", 64'(log_q[k].d), 64'(k + 1));
            chk("t3_last", 64'(log_q[k].last), 64'(k == LANES - 1));
         end
      end

      // End of channel over 57 rows
      do_reset();
      bus.res_ready_i = 1'b1;
      for (int r = 0; r < ROWS + 1; r++) send_row(DW'((r + 1) << 8), 200);
      wait_log((ROWS + 1) * LANES, 400);
      if (log_q.size() >= (ROWS + 1) * LANES) begin
         n_eoc  = 0;
         eoc_at = -1;
         foreach (log_q[i]) if (log_q[i].eoc) begin n_eoc++; eoc_at = i; end
         chk("t4_eoc_count", 64'(n_eoc), 64'd1);
         chk("t4_eoc_index", 64'(eoc_at), 64'd3135);
         chk("t4_eoc_word", 64'(log_q[3135].d), 64'h3837);
         chk("t4_row57_last", 64'(log_q[3191].last), 64'd1);
         chk("t4_row57_no_eoc", 64'(log_q[3191].eoc), 64'd0);
         chk("t4_row57_word", 64'(log_q[3191].d), 64'h3937);
      end

      // Reset at word 20 of row 2 with row 3 buffered
      do_reset();
      bus.res_ready_i = 1'b1;
      send_row(32'h100, 20);
      send_row(32'h200, 20);
      send_row(32'h300, 200);
      wait_log(LANES + 20, 200);
      chk("t5_pre_reset_occ", 64'(occ), 64'(OCC_TWO));
      rst_n = 1'b0;
      #1;
      chk("t5_res_valid_async", 64'(bus.res_valid_o), 64'd0);
      chk("t5_par_ready_async", 64'(bus.par_ready_o), 64'd1);
      release_rst();
      send_row(32'h500, 20);
      wait_log(LANES, 200);
      if (log_q.size() >= LANES) begin
         chk("t5_restart_word0", 64'(log_q[0].d), 64'h500);
         chk("t5_restart_latency", 64'(log_q[0].cyc - acc_cyc[0]), 64'd1);
         chk("t5_row0_no_eoc", 64'(log_q[55].eoc), 64'd0);
      end

      // Load coinciding with the last-word transfer
      do_reset();
      bus.res_ready_i = 1'b1;
      send_row(32'h100, 20);
      wait_log(LANES - 1, 200);
      send_row(32'h200, 20);
      chk("t6_occ_one", 64'(occ), 64'(OCC_ONE));
      wait_log(LANES + 1, 200);
      if (log_q.size() >= LANES + 1 && acc_cyc.size() == 2) begin
         chk("t6_same_edge", 64'(acc_cyc[1]), 64'(log_q[55].cyc));
         chk("t6_next_word0", 64'(log_q[56].d), 64'h200);
         chk("t6_next_cycle", 64'(log_q[56].cyc - acc_cyc[1]), 64'd1);
      end
      repeat (LANES + 4) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fmap_par2ser.md
# fmap_par2ser

Output serializer for the RepVGG conv accelerator. It accepts one complete output row (LANES words, the 56-wide result of the 8×7 PE array) in a single cycle from the accumulator/activator stage. It then streams that row out one DW-bit word per cycle on a valid/ready interface toward the result memory. It is the output counterpart of the input ser2par path: it double-buffers rows so the PE array can deliver the next row while the current one drains.

## Interface
Parameters:
- DW, 32, word width (IW integer + FW fraction fixed-point, passed through untouched)
- LANES, 56, words per row
- ROWS, 56, rows per output channel (feature-map height)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- par_i  in  LANES*DW  row data; word k at bits [k*DW +: DW], word 0 leaves first
- par_valid_i  in  1  row presented
- par_ready_o  out  1  a bank is free; row accepted on par_valid_i && par_ready_o
- res_o  out  DW  serial word
- res_valid_o  out  1  res_o valid
- res_ready_i  in  1  downstream accepts; word transfers on res_valid_o && res_ready_i
- res_last_o  out  1  high with the last word (index LANES-1) of a row
- res_eoc_o  out  1  high with the last word of row ROWS-1 (end of channel)

## Operation
- Storage: two row banks, each LANES×DW, with a full flag per bank, wr_bank and rd_bank pointers (1 bit each), a word index idx (0..LANES-1) and a row counter row (0..ROWS-1).
- Occupancy states: EMPTY (0 full), ONE (1 full), TWO (2 full).
  - Load: EMPTY→ONE, ONE→TWO.
  - Drain of a row's last word: ONE→EMPTY, TWO→ONE.
  - Load and drain in the same cycle keep the occupancy.
- Load: on accept, the whole of par_i is written into bank wr_bank, that bank's full flag sets, and wr_bank toggles.
- par_ready_o = !full[wr_bank]. It is a function of registered state only, with no combinational path from res_ready_i or par_valid_i.
- Drain:
  - res_valid_o = full[rd_bank].
  - res_o = bank[rd_bank][idx].
  - On each transfer idx increments.
  - On the transfer with idx==LANES-1: idx→0, full[rd_bank] clears, rd_bank toggles, and row increments, wrapping ROWS-1→0.
- res_last_o = res_valid_o && idx==LANES-1. res_eoc_o = res_last_o && row==ROWS-1.
- Holding: while res_valid_o && !res_ready_i, res_o, res_last_o and res_eoc_o hold steady.
- No arithmetic: data is stored and forwarded bit-exact, with no rounding, saturation or sign handling.

## Timing
- Reset values:
  - par_ready_o=1, res_valid_o=0, res_last_o=0, res_eoc_o=0, res_o=0.
  - Banks cleared to 0, both pointers 0, idx=0, row=0.
- Latency: a row accepted at edge N with EMPTY occupancy gives res_valid_o=1 and word 0 on res_o in the cycle after edge N.
- Throughput with res_ready_i held 1: one word per cycle, LANES cycles per row. Back-to-back rows produce no bubble if the next row was loaded before the last word of the current row transfers.
- Freed bank: the bank freed by a last-word transfer at edge M makes par_ready_o=1 in the cycle after M. It is not reusable in the same cycle, since par_ready_o is registered-state based.
- Full: in TWO, par_ready_o=0 and par_valid_i is ignored. par_i must be held by the producer until accepted.
- Empty: in EMPTY, res_valid_o=0 and res_ready_i is ignored. idx and row do not move.
- Simultaneous load into wr_bank and drain from rd_bank in the same cycle: both take effect; the two banks are distinct by construction.
- Reset asserted mid-row: all state returns to reset values immediately (asynchronous). Partially drained and buffered rows are discarded, and the row counter restarts at 0.

## Structure
- The shared package acc_pkg holds:
  - DW, LANES, ROWS defaults.
  - The occupancy state encoding (EMPTY/ONE/TWO) used by testbench checkers.
- Sub-module p2s_row_bank (one LANES×DW register bank: parallel load enable, indexed word read) is instantiated twice.
- The top holds the pointers, full flags, idx/row counters and handshake logic.

## Test plan
- Single row: after reset, load row with word k = k+1, res_ready_i=1 → res_o = 1..56 on 56 consecutive cycles starting the cycle after accept, res_last_o only with value 56, par_ready_o stays 1.
- Ping-pong: offer three rows (bases 0x100, 0x200, 0x300) with par_valid_i held, res_ready_i=0 for 10 cycles, then 1.
  - Expect rows 1 and 2 accepted and par_ready_o=0 while in TWO.
  - Row 3 accepted the cycle after row 1's last word transfers.
  - Output 168 words in order with no gap.
- Backpressure: toggle res_ready_i pseudo-randomly over one row → res_o, res_last_o stable while stalled, no word lost or duplicated, order 1..56.
- End of channel: stream 56 rows → res_eoc_o asserted exactly once, with word 56 of row 56. On row 57, row counter has wrapped and res_eoc_o stays low through its last word.
- Reset mid-operation: assert rst_n=0 at word 20 of row 2 with a third row buffered → next cycle res_valid_o=0, par_ready_o=1. The next loaded row streams from word 0 with row count 0.
- Simultaneous events: load a row in the same cycle as the last word of the current row transfers → occupancy stays ONE, the new row's word 0 appears the following cycle.
